// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with a delayed pixel output stage.
// Define VGA_TEST_PATTERN_EN to add i_pattern, which shows 8 vertical colour bars.
module vga_timing_gen #(
    parameter int CNT_W     = 12,
    parameter int COLOR_W   = 8,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int H_POL     = 0,
    parameter int V_POL     = 0,
    parameter int FETCH_LAT = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [3*COLOR_W-1:0] i_color,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                 i_pattern,
`endif
    output logic                 o_req,
    output logic [CNT_W-1:0]     o_x,
    output logic [CNT_W-1:0]     o_y,
    output logic                 o_frame_start,
    output logic                 o_line_start,
    output logic [COLOR_W-1:0]   o_VGA_R,
    output logic [COLOR_W-1:0]   o_VGA_G,
    output logic [COLOR_W-1:0]   o_VGA_B,
    output logic                 o_H_sync,
    output logic                 o_V_sync,
    output logic                 o_sending
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic H_ON = (H_POL != 0);
    localparam logic V_ON = (V_POL != 0);

    // Syncs travel as raw active-high flags; polarity is applied at the pins.
    typedef struct packed {
        logic             act;
        logic             hs;
        logic             vs;
`ifdef VGA_TEST_PATTERN_EN
        logic [CNT_W-1:0] x;
`endif
    } pix_t;

    logic [CNT_W-1:0] h_q;
    logic [CNT_W-1:0] h_d;
    logic [CNT_W-1:0] v_q;
    logic [CNT_W-1:0] v_d;
    logic             h_wrap;

    always_comb begin
        h_wrap = (h_q == H_LAST);
        h_d    = h_wrap ? '0 : h_q + CNT_W'(1);
        v_d    = v_q;
        if (h_wrap) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
        end
    end

    // Parked on the last position so the first enabled tick lands on (0,0).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_q <= H_LAST;
            v_q <= V_LAST;
        end else if (i_en) begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    logic h_act;
    logic v_act;
    pix_t cur;
    pix_t tap;

    always_comb begin
        h_act         = (h_q < H_ACT);
        v_act         = (v_q < V_ACT);
        o_req         = h_act && v_act;
        o_x           = o_req ? h_q : '0;
        o_y           = o_req ? v_q : '0;
        o_frame_start = (h_q == '0) && (v_q == '0);
        o_line_start  = (h_q == '0) && v_act;
        cur           = '0;
        cur.act       = o_req;
        cur.hs        = (h_q >= HS_BEG) && (h_q < HS_END);
        cur.vs        = (v_q >= VS_BEG) && (v_q < VS_END);
`ifdef VGA_TEST_PATTERN_EN
        cur.x         = o_x;
`endif
    end

    generate
        if (FETCH_LAT == 0) begin : g_no_dly
            assign tap = cur;
        end else begin : g_dly
            pix_t dly_q [FETCH_LAT];
            pix_t dly_d [FETCH_LAT];

            always_comb begin
                dly_d[0] = cur;
                for (int i = 1; i < FETCH_LAT; i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int i = 0; i < FETCH_LAT; i++) begin
                        dly_q[i] <= '0;
                    end
                end else if (i_en) begin
                    for (int i = 0; i < FETCH_LAT; i++) begin
                        dly_q[i] <= dly_d[i];
                    end
                end
            end

            assign tap = dly_q[FETCH_LAT-1];
        end
    endgenerate

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;

    // floor(x*8/H_ACTIVE) as a threshold search, avoiding a divider.
    always_comb begin
        bar = '0;
        for (int b = 1; b < 8; b++) begin
            if (32'(tap.x) * 32'd8 >= 32'(b) * 32'(H_ACTIVE)) begin
                bar = 3'(b);
            end
        end
    end
`endif

    logic [COLOR_W-1:0] r_q;
    logic [COLOR_W-1:0] r_d;
    logic [COLOR_W-1:0] g_q;
    logic [COLOR_W-1:0] g_d;
    logic [COLOR_W-1:0] b_q;
    logic [COLOR_W-1:0] b_d;
    logic               hs_q;
    logic               hs_d;
    logic               vs_q;
    logic               vs_d;
    logic               snd_q;
    logic               snd_d;

    always_comb begin
        snd_d = tap.act;
        hs_d  = tap.hs ? H_ON : ~H_ON;
        vs_d  = tap.vs ? V_ON : ~V_ON;
        r_d   = '0;
        g_d   = '0;
        b_d   = '0;
        if (tap.act) begin
            {b_d, g_d, r_d} = i_color;
`ifdef VGA_TEST_PATTERN_EN
            if (i_pattern) begin
                r_d = {COLOR_W{bar[0]}};
                g_d = {COLOR_W{bar[1]}};
                b_d = {COLOR_W{bar[2]}};
            end
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
            hs_q  <= ~H_ON;
            vs_q  <= ~V_ON;
            snd_q <= 1'b0;
        end else if (i_en) begin
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            snd_q <= snd_d;
        end
    end

    assign o_VGA_R   = r_q;
    assign o_VGA_G   = g_q;
    assign o_VGA_B   = b_q;
    assign o_H_sync  = hs_q;
    assign o_V_sync  = vs_q;
    assign o_sending = snd_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: small-raster bench with a tick-count reference model.
// Table vectors, random enables/colours, async mid-frame reset, 1-of-4 enables.
module tb_vga_timing_gen;

    localparam int CW   = 8;
    localparam int COLW = 4;
    localparam int HA   = 16;
    localparam int HFP  = 2;
    localparam int HS   = 3;
    localparam int HBP  = 2;
    localparam int VA   = 6;
    localparam int VFP  = 1;
    localparam int VS   = 2;
    localparam int VBP  = 1;
    localparam int HP   = 0;
    localparam int VP   = 1;
    localparam int FL   = 2;
    localparam int HT   = HA + HFP + HS + HBP;
    localparam int VT   = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [3*COLW-1:0] color;
    logic              pattern;
    logic              req;
    logic [CW-1:0]     x;
    logic [CW-1:0]     y;
    logic              fs;
    logic              ls;
    logic [COLW-1:0]   r;
    logic [COLW-1:0]   g;
    logic [COLW-1:0]   b;
    logic              hsync;
    logic              vsync;
    logic              sending;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CNT_W(CW), .COLOR_W(COLW),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_POL(HP), .V_POL(VP), .FETCH_LAT(FL)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_en(en),
        .i_color(color),
`ifdef VGA_TEST_PATTERN_EN
        .i_pattern(pattern),
`endif
        .o_req(req),
        .o_x(x),
        .o_y(y),
        .o_frame_start(fs),
        .o_line_start(ls),
        .o_VGA_R(r),
        .o_VGA_G(g),
        .o_VGA_B(b),
        .o_H_sync(hsync),
        .o_V_sync(vsync),
        .o_sending(sending)
    );

    typedef struct packed {
        logic              req;
        logic [CW-1:0]     x;
        logic [CW-1:0]     y;
        logic              fs;
        logic              ls;
        logic [3*COLW-1:0] rgb;
        logic              hs;
        logic              vs;
        logic              snd;
    } obs_t;

    typedef struct {
        int   n;
        logic req;
        int   x;
        int   y;
        logic fs;
        logic ls;
        logic hs;
        logic vs;
        logic snd;
    } vec_t;

    int                compared = 0;
    int                mismatched = 0;
    int                n = 0;
    logic [3*COLW-1:0] col_n = '0;
    logic              pat_n = 1'b0;

    // n = enabled ticks since reset release; counters sit at raster position
    // n-1, the pins show position n-2-FL with the colour sampled at tick n.
    function automatic obs_t model(int nt, logic [3*COLW-1:0] col, logic pat);
        obs_t e;
        int   p;
        int   h;
        int   v;
        int   k;
        logic act;
        logic hsa;
        logic vsa;
        e   = '0;
        act = 1'b0;
        hsa = 1'b0;
        vsa = 1'b0;
        if (nt >= 1) begin
            p     = (nt - 1) % FRAME;
            h     = p % HT;
            v     = p / HT;
            e.req = (h < HA) && (v < VA);
            if (e.req) begin
                e.x = CW'(h);
                e.y = CW'(v);
            end
            e.fs = (p == 0);
            e.ls = (h == 0) && (v < VA);
        end
        if (nt - 2 - FL >= 0) begin
            p   = (nt - 2 - FL) % FRAME;
            h   = p % HT;
            v   = p / HT;
            act = (h < HA) && (v < VA);
            hsa = (h >= HA + HFP) && (h < HA + HFP + HS);
            vsa = (v >= VA + VFP) && (v < VA + VFP + VS);
            k   = (h * 8) / HA;
`ifdef VGA_TEST_PATTERN_EN
            if (pat) begin
                col = {{COLW{k[2]}}, {COLW{k[1]}}, {COLW{k[0]}}};
            end
`else
            if (pat && k > 99) begin
                col = '0;
            end
`endif
        end
        e.snd = act;
        e.rgb = act ? col : '0;
        e.hs  = hsa ? (HP != 0) : (HP == 0);
        e.vs  = vsa ? (VP != 0) : (VP == 0);
        return e;
    endfunction

    task automatic check(input string name, input obs_t e);
        obs_t a;
        a = '{req, x, y, fs, ls, {b, g, r}, hsync, vsync, sending};
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s n=%0d actual=%h required=%h", name, n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (en && !rst) begin
            n++;
            col_n = color;
            pat_n = pattern;
        end
        @(negedge clk);
    endtask

    localparam logic [3*COLW-1:0] C = 12'hA5C;

    initial begin
        vec_t tbl [12];
        obs_t e;
        bit   found;

        tbl[0]  = '{0,   0, 0, 0, 0, 0, 1, 0, 0};
        tbl[1]  = '{1,   1, 0, 0, 1, 1, 1, 0, 0};
        tbl[2]  = '{2,   1, 1, 0, 0, 0, 1, 0, 0};
        tbl[3]  = '{4,   1, 3, 0, 0, 0, 1, 0, 1};
        tbl[4]  = '{19,  0, 0, 0, 0, 0, 1, 0, 1};
        tbl[5]  = '{22,  0, 0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{24,  1, 0, 1, 0, 1, 0, 0, 0};
        tbl[7]  = '{25,  1, 1, 1, 0, 0, 1, 0, 0};
        tbl[8]  = '{162, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{165, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[10] = '{231, 1, 0, 0, 1, 1, 0, 0, 0};
        tbl[11] = '{234, 1, 3, 0, 0, 0, 1, 0, 1};

        rst     = 1'b1;
        en      = 1'b0;
        color   = C;
        pattern = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        n   = 0;

        for (int i = 0; i < 12; i++) begin
            for (int c = 0; c < 400 && n < tbl[i].n; c++) begin
                step();
            end
            e     = '0;
            e.req = tbl[i].req;
            e.x   = CW'(tbl[i].x);
            e.y   = CW'(tbl[i].y);
            e.fs  = tbl[i].fs;
            e.ls  = tbl[i].ls;
            e.rgb = tbl[i].snd ? C : '0;
            e.hs  = tbl[i].hs;
            e.vs  = tbl[i].vs;
            e.snd = tbl[i].snd;
            check($sformatf("tbl%0d", i), e);
        end

        for (int i = 0; i < 1200; i++) begin
            en      = 1'($urandom_range(0, 1));
            color   = 12'($urandom);
            pattern = 1'($urandom_range(0, 1));
            step();
            check("rand", model(n, col_n, pat_n));
        end

        found = 0;
        en    = 1'b1;
        for (int i = 0; i < 2000 && !found; i++) begin
            e = model(n, col_n, pat_n);
            if (e.snd && (n % FRAME) > HT) begin
                found = 1;
            end else begin
                color = 12'($urandom);
                step();
            end
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL seek_mid_frame n=%0d actual=timeout required=active", n);
        end

        rst = 1'b1;
        #1;
        check("async_rst", model(0, '0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            en = 1'($urandom_range(0, 1));
            step();
            check("rst_hold", model(0, '0, 1'b0));
        end
        rst = 1'b0;
        n   = 0;
        check("rst_rel", model(0, '0, 1'b0));

        for (int i = 0; i < 1600; i++) begin
            en      = (i % 4 == 3);
            color   = 12'($urandom);
            pattern = 1'($urandom_range(0, 1));
            step();
            check("en4", model(n, col_n, pat_n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
